// File: rtl/dm_param_pkg.sv
// rtl/dm_param_pkg.sv - shared size codes, FSM states and shape-fault helper for the data memory
package dm_param_pkg;

    localparam int STO_DM = 3072;

    localparam logic [1:0] DM_SZ_B = 2'b00;
    localparam logic [1:0] DM_SZ_H = 2'b01;
    localparam logic [1:0] DM_SZ_W = 2'b10;

    typedef enum logic {
        DM_ST_INIT = 1'b0,
        DM_ST_RUN  = 1'b1
    } dm_state_e;

    // Misaligned half/word or the reserved size code; range faults are checked separately.
    function automatic logic dm_size_fault(input logic [1:0] size, input logic [1:0] off);
        case (size)
            DM_SZ_B: return 1'b0;
            DM_SZ_H: return off[0];
            DM_SZ_W: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// rtl/dm_load_ext.sv - selects byte/half/word from a memory word and sign/zero-extends it
module dm_load_ext
    import dm_param_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (size)
            DM_SZ_B: result = {{24{sext & byte_sel[7]}}, byte_sel};
            DM_SZ_H: result = {{16{sext & half_sel[15]}}, half_sel};
            DM_SZ_W: result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/dm_param.sv
// rtl/dm_param.sv - parametrised byte-lane data memory with registered load path and zeroing sweep
module dm_param
    import dm_param_pkg::*;
#(
    parameter int DEPTH         = STO_DM,
    parameter int ADDR_W        = 15,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    output logic              ready,
    output logic [31:0]       dout,
    output logic              dout_vld,
    output logic              err
);

    localparam int              IDX_W   = ADDR_W - 2;
    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0]  DEPTH_L = (IDX_W + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);
    localparam dm_state_e       RST_ST  = (INIT_ON_RESET != 0) ? DM_ST_INIT : DM_ST_RUN;

    dm_state_e     state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          ready_q, ready_d;
    logic [31:0]   dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;
    logic          err_q, err_d;

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             accept;
    logic             fault;
    logic             sweep;
    logic             mem_we;
    logic [AW-1:0]    mem_idx;
    logic [3:0]       mem_mask;
    logic [31:0]      mem_wdata;
    logic [31:0]      rd_word;
    logic [31:0]      ext_word;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= RST_ST;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == DM_ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST) begin
                state_d = DM_ST_RUN;
                ptr_d   = '0;
            end
        end
    end

    // ready is registered so it reads 0 under reset even when the sweep is skipped.
    always_comb begin
        sweep   = (state_q == DM_ST_INIT);
        ready_d = (state_d == DM_ST_RUN);
    end

    always_comb begin
        idx     = addr[ADDR_W-1:2];
        off     = addr[1:0];
        accept  = req & ready_q;
        fault   = ({1'b0, idx} >= DEPTH_L) | dm_size_fault(size, off);
        rd_word = fault ? '0 : mem[idx[AW-1:0]];
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = idx[AW-1:0];
        mem_mask  = '0;
        mem_wdata = '0;
        if (sweep) begin
            mem_we   = 1'b1;
            mem_idx  = ptr_q;
            mem_mask = 4'hF;
        end else if (accept & we & ~fault) begin
            mem_we = 1'b1;
            case (size)
                DM_SZ_B: begin
                    mem_mask  = 4'b0001 << off;
                    mem_wdata = {4{din[7:0]}};
                end
                DM_SZ_H: begin
                    mem_mask  = off[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{din[15:0]}};
                end
                default: begin
                    mem_mask  = 4'hF;
                    mem_wdata = din;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_mask[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    dm_load_ext u_load_ext (
        .word   (rd_word),
        .offset (off),
        .size   (size),
        .sext   (sext),
        .result (ext_word)
    );

    // A faulting load reads a zeroed word, so ext_word is already 0 in that case.
    always_comb begin
        dout_d     = dout_q;
        dout_vld_d = accept & ~we;
        err_d      = accept & fault;
        if (accept & ~we) dout_d = ext_word;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ready_q    <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            err_q      <= err_d;
        end
    end

    assign ready    = ready_q;
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dm_param.sv
// tb/tb_dm_param.sv - directed and random checks of dm_param against a byte-addressed model
module tb_dm_param;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 7;

    logic              clk  = 1'b0;
    logic              clr  = 1'b1;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       din  = '0;
    logic              req  = 1'b0;
    logic              we   = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              sext = 1'b0;
    logic              ready;
    logic [31:0]       dout;
    logic              dout_vld;
    logic              err;

    int          checks   = 0;
    int          errors   = 0;
    logic [7:0]  mb [DEPTH*4];
    logic [31:0] exp_dout = '0;

    dm_param #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_ON_RESET(1)) dut (
        .clk      (clk),
        .clr      (clr),
        .addr     (addr),
        .din      (din),
        .req      (req),
        .we       (we),
        .size     (size),
        .sext     (sext),
        .ready    (ready),
        .dout     (dout),
        .dout_vld (dout_vld),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input int sz);
        return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    endfunction

    function automatic bit model_fault(input int a, input int sz);
        if (a / 4 >= DEPTH) return 1'b1;
        if (sz == 3) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input int a, input int sz, input bit sx);
        logic [31:0] v;
        int n;
        n = nbytes(sz);
        v = '0;
        for (int i = 0; i < n; i++) v = v | ({24'b0, mb[a+i]} << (8*i));
        if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
    endtask

    task automatic acc(input string tag, input bit w, input int sz, input bit sx, input int a,
                       input logic [31:0] d);
        bit flt;
        logic [31:0] e;
        flt  = model_fault(a, sz);
        e    = flt ? 32'h0 : model_load(a, sz, sx);
        req  = 1'b1;
        we   = w;
        size = sz[1:0];
        sext = sx;
        addr = a[ADDR_W-1:0];
        din  = d;
        @(posedge clk); #1;
        req = 1'b0;
        if (w && !flt) begin
            for (int i = 0; i < nbytes(sz); i++) mb[a+i] = d[8*i +: 8];
        end
        if (!w) exp_dout = e;
        chk({tag, "_err"}, 32'(err), 32'(flt));
        chk({tag, "_vld"}, 32'(dout_vld), 32'(!w));
        chk({tag, "_dout"}, dout, exp_dout);
    endtask

    task automatic do_clr(input string tag);
        #2 clr = 1'b1;
        #1;
        exp_dout = '0;
        chk({tag, "_ready"}, 32'(ready), 32'h0);
        chk({tag, "_dout"}, dout, 32'h0);
        chk({tag, "_vld"}, 32'(dout_vld), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // Random requests while sweeping must be ignored; ready rises on the DEPTH-th edge.
    task automatic sweep_check(input string tag);
        for (int k = 1; k <= DEPTH; k++) begin
            req  = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 2));
            addr = ADDR_W'($urandom_range(0, 63));
            din  = $urandom;
            @(posedge clk); #1;
            chk({tag, "_ready"}, 32'(ready), 32'(k == DEPTH));
            chk({tag, "_vld"}, 32'(dout_vld), 32'h0);
            chk({tag, "_err"}, 32'(err), 32'h0);
            chk({tag, "_dout"}, dout, exp_dout);
        end
        req = 1'b0;
        model_clear();
    endtask

    initial begin
        int run;
        int w, sz, a;

        @(posedge clk); #1;
        do_clr("rst0");
        sweep_check("sweep0");
        for (int i = 0; i < DEPTH; i++) acc("zero_lw0", 1'b0, 2, 1'b0, i*4, 32'h0);

        for (int i = 0; i < DEPTH; i++) acc("poison_sw", 1'b1, 2, 1'b0, i*4, $urandom | 32'h1);
        acc("pre_clr_lw", 1'b0, 2, 1'b0, 12, 32'h0);
        acc("pre_clr_flt", 1'b1, 1, 1'b0, 5, 32'h1234);
        do_clr("rst1");
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            chk("part_sweep_ready", 32'(ready), 32'h0);
        end
        do_clr("rst_mid");
        sweep_check("sweep1");
        for (int i = 0; i < DEPTH; i++) acc("zero_lw1", 1'b0, 2, 1'b0, i*4, 32'h0);

        acc("merge_sw", 1'b1, 2, 1'b0, 4, 32'h1122_3344);
        acc("merge_sb", 1'b1, 0, 1'b0, 6, 32'h0000_00AA);
        acc("merge_sh", 1'b1, 1, 1'b0, 4, 32'h0000_BEEF);
        acc("merge_lw", 1'b0, 2, 1'b0, 4, 32'h0);
        chk("merge_const", dout, 32'h11AA_BEEF);

        acc("ext_sw", 1'b1, 2, 1'b0, 8, 32'h80FF_7F01);
        acc("lb_0a", 1'b0, 0, 1'b1, 10, 32'h0);
        chk("lb_0a_const", dout, 32'hFFFF_FFFF);
        acc("lbu_0b", 1'b0, 0, 1'b0, 11, 32'h0);
        chk("lbu_0b_const", dout, 32'h0000_0080);
        acc("lh_0a", 1'b0, 1, 1'b1, 10, 32'h0);
        chk("lh_0a_const", dout, 32'hFFFF_80FF);
        acc("lhu_08", 1'b0, 1, 1'b0, 8, 32'h0);
        chk("lhu_08_const", dout, 32'h0000_7F01);
        acc("lb_08", 1'b0, 0, 1'b1, 8, 32'h0);
        chk("lb_08_const", dout, 32'h0000_0001);

        acc("flt_sh05", 1'b1, 1, 1'b0, 5, 32'h0000_5555);
        acc("flt_sw0a", 1'b1, 2, 1'b0, 10, 32'h6666_6666);
        acc("flt_sw44", 1'b1, 2, 1'b0, 68, 32'h7777_7777);
        acc("flt_sz3_st", 1'b1, 3, 1'b0, 8, 32'h8888_8888);
        acc("flt_lw40", 1'b0, 2, 1'b0, 64, 32'h0);
        acc("flt_sz3_ld", 1'b0, 3, 1'b1, 8, 32'h0);
        acc("unch_lw04", 1'b0, 2, 1'b0, 4, 32'h0);
        chk("unch_04_const", dout, 32'h11AA_BEEF);
        acc("unch_lw08", 1'b0, 2, 1'b0, 8, 32'h0);
        chk("unch_08_const", dout, 32'h80FF_7F01);

        acc("b2b_sw", 1'b1, 2, 1'b0, 12, 32'hDEAD_BEEF);
        acc("b2b_lw", 1'b0, 2, 1'b0, 12, 32'h0);
        chk("b2b_const", dout, 32'hDEAD_BEEF);

        run = 0;
        for (int i = 0; i < 8; i++) begin
            acc("burst_lw", 1'b0, 2, 1'b0, (i % DEPTH) * 4, 32'h0);
            if (dout_vld === 1'b1) run++;
        end
        chk("burst_vld_run", 32'(run), 32'd8);

        @(posedge clk); #1;
        chk("idle_vld", 32'(dout_vld), 32'h0);
        chk("idle_err", 32'(err), 32'h0);
        chk("idle_dout", dout, exp_dout);

        for (int n = 0; n < 300; n++) begin
            w  = $urandom_range(0, 1);
            sz = $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 127);
            else a = $urandom_range(0, 63) & ~(nbytes(sz) - 1);
            acc("rand", w[0], sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
